merger_leaf_loader: RTL and testbench
=====================================

Name: merger_leaf_loader

Overview:
Scheduler that refills the 2*L leaf input FIFOs of the merger tree from one shared single-read-port sequence memory. Each leaf owns a contiguous sequence of LEN_SEQ words. After the sequence, the loader writes PAD_CNT zero terminator words into that leaf's FIFO. A round-robin arbiter shares the memory port and the single FIFO write bus among leaves. It sits between the sequence memory and the IN FIFO bank of the merger tree.

Parameters:
LEAF_CNT, 16, number of leaf FIFOs (2*L).
DATA_WIDTH, 32, word width.
LEN_SEQ, 128, words per leaf sequence; leaf i base address = i*LEN_SEQ.
ADDR_WIDTH, 11, memory address width; must satisfy 2**ADDR_WIDTH >= LEAF_CNT*LEN_SEQ.
PAD_CNT, 20, zero words appended per leaf after its sequence.
RD_LATENCY, 1, cycles from the read-issue edge to the edge that samples i_mem_data (>=1).

Ports:
i_clk  in  1  clock, all logic on posedge.
i_rst_n  in  1  asynchronous active-low reset.
i_start  in  1  one-cycle pulse; starts a load pass.
i_fifo_full  in  LEAF_CNT  per-leaf FIFO full flag.
o_fifo_write  out  LEAF_CNT  one-hot write strobe; at most one bit set.
o_fifo_data  out  DATA_WIDTH  shared write data to all leaf FIFOs.
o_mem_rd_en  out  1  memory read strobe.
o_mem_addr  out  ADDR_WIDTH  memory read address.
i_mem_data  in  DATA_WIDTH  read data, valid RD_LATENCY cycles after issue.
o_busy  out  1  high in RUN and DRAIN.
o_done  out  1  level, high in DONE.

Behaviour:
- Reset, asynchronous: all outputs 0; state IDLE; per-leaf counters and in-flight flags cleared.
- States:
  - IDLE: --i_start--> RUN. On entry to RUN: each leaf i gets addr=i*LEN_SEQ, rem_seq=LEN_SEQ, rem_pad=PAD_CNT.
  - RUN: --all leaves finished (rem_seq==0 and rem_pad==0)--> DRAIN.
  - DRAIN: --issue pipeline empty--> DONE.
  - DONE: --i_start--> RUN, with a full reinit.
  - i_start is ignored in RUN and DRAIN.
- Leaf i is eligible when all of these hold: in RUN, not finished, i_fifo_full[i]==0, no in-flight op tagged i.
  - This caps outstanding ops at one per leaf, so a FIFO that is not full can never be overrun.
- Arbitration:
  - Round-robin, one grant per cycle.
  - Search starts at last_grant+1 mod LEAF_CNT; after reset or start, the search starts at leaf 0.
  - No eligible leaf means no grant; the pointer holds.
- Grant at edge k, data phase (rem_seq>0):
  - o_mem_rd_en=1 and o_mem_addr=addr[i] in cycle k.
  - addr[i]++, rem_seq[i]--.
  - Push tag {leaf i, pad=0} into an issue pipeline of RD_LATENCY stages.
- Grant at edge k, pad phase (rem_seq==0, rem_pad>0):
  - No memory read; o_mem_rd_en=0.
  - rem_pad[i]--.
  - Push tag {leaf i, pad=1} through the same pipeline, so write order and latency are identical to the data phase.
- Pipeline exit at edge k+RD_LATENCY, registered:
  - o_fifo_write[i]=1 in cycle k+RD_LATENCY, for one cycle.
  - o_fifo_data = pad ? 0 : i_mem_data.
  - Leaf i's in-flight flag clears at that same edge, so leaf i is eligible from edge k+RD_LATENCY.
  - Grant-to-write latency is RD_LATENCY cycles. Per-leaf throughput is 1/(RD_LATENCY+1) per cycle; aggregate throughput is 1 word per cycle.
- Full rising while an op is in flight: the write still occurs (slot was reserved); the leaf gets no new grants until full drops.
- o_fifo_data holds its last value when no write is issued; o_mem_addr holds its value when o_mem_rd_en=0.
- LEN_SEQ==0 degenerates to pad-only; PAD_CNT==0 means no terminators.
- Reset mid-operation discards in-flight ops; no write is issued after reset is released until a new i_start.

Decomposition:
- Package merger_pkg:
  - LEAF_CNT, DATA_WIDTH, LEN_SEQ, PAD_CNT constants.
  - Leaf-index width constant ($clog2(LEAF_CNT)).
  - Issue-tag struct {leaf idx, pad bit, valid}.
  - Loader state enum {IDLE, RUN, DRAIN, DONE}.
- One sub-module, rr_arbiter: parameterised LEAF_CNT; request vector in; one-hot grant and grant index out; internal pointer advance on grant.

Test Plan:
Bench setup: LEAF_CNT=4, LEN_SEQ=4, PAD_CNT=2, RD_LATENCY=1, memory word[a]=a+1, all i_fifo_full=0.
1. Reset asserted mid-cycle, then held -> all outputs 0 immediately; no activity until i_start.
2. Start pulse, no backpressure -> grants on leaves 0,1,2,3,0,…; first write is o_fifo_write=0001 with data 1 one cycle after the first grant. Leaf 1 receives 5,6,7,8,0,0. Total 24 writes, then o_done=1 one cycle after the last write.
3. i_fifo_full[2]=1 from start -> leaves 0,1,3 complete (18 writes) and the FSM stays in RUN. Release full -> leaf 2 receives 9,10,11,12,0,0, then DONE.
4. Full[0] held until leaves 1-3 finish, then released -> leaf 0 is granted every 2nd cycle (RD_LATENCY+1); o_mem_rd_en toggles 1,0,1,0.
5. Reset pulse after 7 writes -> outputs clear and pending writes are dropped. A new i_start restarts from base addresses (leaf 0 data 1 again).
6. i_start pulsed during RUN -> no effect (write sequence identical to scenario 2). i_start in DONE -> o_done drops and the full 24-write pass repeats.

Source files
------------

// File: rtl/merger_leaf_loader_pkg.sv
// Shared definitions for the merger-tree leaf loader.
// Contents:
//   default sizing constants (leaf count, word width, sequence length, padding)
//   leaf index width, issue-pipeline tag struct, loader state enum
package merger_pkg;

  localparam int unsigned MRG_LEAF_CNT   = 16;
  localparam int unsigned MRG_DATA_WIDTH = 32;
  localparam int unsigned MRG_LEN_SEQ    = 128;
  localparam int unsigned MRG_PAD_CNT    = 20;

  localparam int unsigned LEAF_IDX_W = $clog2(MRG_LEAF_CNT);

  // One entry of the read-issue pipeline: which leaf gets the word and
  // whether it is a zero terminator rather than memory data.
  typedef struct packed {
    logic [LEAF_IDX_W-1:0] leaf;
    logic                  pad;
    logic                  valid;
  } issue_tag_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } loader_state_t;

endpackage

// File: rtl/merger_leaf_loader_arb.sv
// Round-robin arbiter, one grant per cycle.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clear           restart the search at index 0 on the next cycle
//   req             request vector
//   grant           one-hot grant (combinational)
//   grant_idx       index of the granted requester
module rr_arbiter #(
  parameter int unsigned LEAF_CNT = 16,
  parameter int unsigned IDX_W    = (LEAF_CNT > 1) ? $clog2(LEAF_CNT) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic [LEAF_CNT-1:0] req,
  output logic [LEAF_CNT-1:0] grant,
  output logic [IDX_W-1:0]    grant_idx
);

  logic [IDX_W-1:0] last;

  // Search begins one past the last winner; parking "last" at LEAF_CNT-1
  // makes the next search begin at index 0.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] cand;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned off = 1; off <= LEAF_CNT; off++) begin
      cand = IDX_W'((32'(last) + off) % LEAF_CNT);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IDX_W'(LEAF_CNT - 1);
    end else if (clear) begin
      last <= IDX_W'(LEAF_CNT - 1);
    end else if (|grant) begin
      last <= grant_idx;
    end
  end

endmodule

// File: rtl/merger_leaf_loader.sv
// Refills the leaf input FIFOs of the merger tree from one shared
// single-read-port sequence memory, then appends zero terminators per leaf.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          one-cycle pulse starting a load pass (IDLE/DONE only)
//   i_fifo_full      per-leaf FIFO full flags
//   o_fifo_write     one-hot FIFO write strobe
//   o_fifo_data      shared FIFO write data
//   o_mem_rd_en      memory read strobe
//   o_mem_addr       memory read address
//   i_mem_data       memory read data, RD_LATENCY cycles after issue
//   o_busy, o_done   status levels
module merger_leaf_loader
  import merger_pkg::*;
#(
  parameter int unsigned LEAF_CNT   = MRG_LEAF_CNT,
  parameter int unsigned DATA_WIDTH = MRG_DATA_WIDTH,
  parameter int unsigned LEN_SEQ    = MRG_LEN_SEQ,
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned PAD_CNT    = MRG_PAD_CNT,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [LEAF_CNT-1:0]   i_fifo_full,
  output logic [LEAF_CNT-1:0]   o_fifo_write,
  output logic [DATA_WIDTH-1:0] o_fifo_data,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned IDX_W = (LEAF_CNT > 1) ? $clog2(LEAF_CNT) : 1;
  localparam int unsigned SEQ_W = ($clog2(LEN_SEQ + 1) > 0) ? $clog2(LEN_SEQ + 1) : 1;
  localparam int unsigned PAD_W = ($clog2(PAD_CNT + 1) > 0) ? $clog2(PAD_CNT + 1) : 1;

  loader_state_t state, state_next;

  logic [ADDR_WIDTH-1:0] addr    [LEAF_CNT];
  logic [SEQ_W-1:0]      rem_seq [LEAF_CNT];
  logic [PAD_W-1:0]      rem_pad [LEAF_CNT];
  issue_tag_t            pipe    [RD_LATENCY];

  logic [LEAF_CNT-1:0] inflight, finished, req, grant;
  logic [IDX_W-1:0]    grant_idx, exit_leaf;
  logic                start_pass, pipe_busy;

  always_comb begin
    finished = '0;
    req      = '0;
    for (int unsigned i = 0; i < LEAF_CNT; i++) begin
      finished[i] = (rem_seq[i] == '0) && (rem_pad[i] == '0);
      req[i]      = (state == ST_RUN) && !finished[i] && !i_fifo_full[i] && !inflight[i];
    end
  end

  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned j = 0; j < RD_LATENCY; j++) begin
      pipe_busy = pipe_busy | pipe[j].valid;
    end
  end

  assign exit_leaf = IDX_W'(pipe[RD_LATENCY-1].leaf);

  rr_arbiter #(
    .LEAF_CNT (LEAF_CNT),
    .IDX_W    (IDX_W)
  ) u_arb (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clear     (start_pass),
    .req       (req),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    start_pass = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_next = ST_RUN;
          start_pass = 1'b1;
        end
      end
      ST_RUN:   if (&finished) state_next = ST_DRAIN;
      ST_DRAIN: if (!pipe_busy) state_next = ST_DONE;
      default:  state_next = ST_IDLE;
    endcase
  end

  assign o_busy = (state == ST_RUN) || (state == ST_DRAIN);
  assign o_done = (state == ST_DONE);

  // Pad grants travel the same pipeline as reads so every leaf sees a
  // fixed grant-to-write latency regardless of phase.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < LEAF_CNT; i++) begin
        addr[i]    <= '0;
        rem_seq[i] <= '0;
        rem_pad[i] <= '0;
      end
      for (int unsigned j = 0; j < RD_LATENCY; j++) pipe[j] <= '0;
      inflight     <= '0;
      o_fifo_write <= '0;
      o_fifo_data  <= '0;
      o_mem_rd_en  <= 1'b0;
      o_mem_addr   <= '0;
    end else begin
      o_mem_rd_en  <= 1'b0;
      o_fifo_write <= '0;
      pipe[0]      <= '0;
      for (int unsigned j = 1; j < RD_LATENCY; j++) pipe[j] <= pipe[j-1];

      if (pipe[RD_LATENCY-1].valid) begin
        o_fifo_write         <= LEAF_CNT'(1) << exit_leaf;
        o_fifo_data          <= pipe[RD_LATENCY-1].pad ? '0 : i_mem_data;
        inflight[exit_leaf]  <= 1'b0;
      end

      if (start_pass) begin
        for (int unsigned i = 0; i < LEAF_CNT; i++) begin
          addr[i]    <= ADDR_WIDTH'(i * LEN_SEQ);
          rem_seq[i] <= SEQ_W'(LEN_SEQ);
          rem_pad[i] <= PAD_W'(PAD_CNT);
        end
        inflight <= '0;
      end else if (|grant) begin
        pipe[0]             <= '{leaf: LEAF_IDX_W'(grant_idx),
                                 pad: (rem_seq[grant_idx] == '0),
                                 valid: 1'b1};
        inflight[grant_idx] <= 1'b1;
        if (rem_seq[grant_idx] != '0) begin
          o_mem_rd_en        <= 1'b1;
          o_mem_addr         <= addr[grant_idx];
          addr[grant_idx]    <= addr[grant_idx] + ADDR_WIDTH'(1);
          rem_seq[grant_idx] <= rem_seq[grant_idx] - SEQ_W'(1);
        end else begin
          rem_pad[grant_idx] <= rem_pad[grant_idx] - PAD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_merger_leaf_loader.sv
module tb_merger_leaf_loader;

  localparam int unsigned NL = 4;
  localparam int unsigned NS = 4;
  localparam int unsigned NP = 2;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [NL-1:0] fifo_full = '0;
  logic [NL-1:0] fifo_write;
  logic [DW-1:0] fifo_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          busy, done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int last_wr_cyc = 0;
  bit chk_order = 1'b0;

  logic [DW-1:0] exp_q [NL][$];
  int            order_q [$];

  merger_leaf_loader #(
    .LEAF_CNT   (NL),
    .DATA_WIDTH (DW),
    .LEN_SEQ    (NS),
    .ADDR_WIDTH (AW),
    .PAD_CNT    (NP),
    .RD_LATENCY (1)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_fifo_full  (fifo_full),
    .o_fifo_write (fifo_write),
    .o_fifo_data  (fifo_data),
    .o_mem_rd_en  (mem_rd_en),
    .o_mem_addr   (mem_addr),
    .i_mem_data   (mem_data),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Memory word[a] = a+1, sampled one edge after the read issue edge.
  always_comb mem_data = 32'(mem_addr) + 32'd1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_expected(input bit with_order);
    for (int l = 0; l < int'(NL); l++) begin
      for (int w = 0; w < int'(NS); w++) exp_q[l].push_back(DW'(l * NS + w + 1));
      for (int p = 0; p < int'(NP); p++) exp_q[l].push_back('0);
    end
    order_q.delete();
    if (with_order)
      for (int r = 0; r < int'(NS + NP); r++)
        for (int l = 0; l < int'(NL); l++) order_q.push_back(l);
    chk_order = with_order;
    wr_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, done, 1);
  endtask

  task automatic check_queues_empty(input string tag);
    for (int l = 0; l < int'(NL); l++)
      check($sformatf("%s_left_leaf%0d", tag, l), exp_q[l].size(), 0);
  endtask

  // Write monitor / scoreboard consumer.
  always @(negedge clk) begin : mon
    int leaf;
    int exp_leaf;
    if (rst_n === 1'b1 && fifo_write !== '0) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      check("wr_onehot", $onehot(fifo_write), 1);
      leaf = 0;
      for (int i = 0; i < int'(NL); i++) if (fifo_write[i]) leaf = i;
      if (chk_order) begin
        exp_leaf = (order_q.size() != 0) ? order_q.pop_front() : -1;
        check("wr_order", leaf, exp_leaf);
      end
      checks++;
      assert (exp_q[leaf].size() != 0)
      else begin
        errors++;
        $error("FAIL wr_unexpected: leaf %0d observed data %0h expected no write", leaf, fifo_data);
      end
      if (exp_q[leaf].size() != 0)
        check($sformatf("wr_data_leaf%0d", leaf), fifo_data, exp_q[leaf].pop_front());
    end
  end

  initial begin
    #100000;
    $error("FAIL watchdog: observed no end expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int done_cyc;
    int n;

    // 1. reset state, idle without start
    repeat (3) @(negedge clk);
    check("rst_write", fifo_write, 0);
    check("rst_data", fifo_data, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("idle_writes", wr_cnt, 0);
    check("idle_busy", busy, 0);

    // 2. full pass, no backpressure
    load_expected(1'b1);
    pulse_start();
    check("s2_busy", busy, 1);
    @(negedge clk);
    check("s2_first_rd", mem_rd_en, 1);
    check("s2_first_addr", mem_addr, 0);
    check("s2_no_write_yet", fifo_write, 0);
    @(negedge clk);
    check("s2_first_wr", fifo_write, 4'b0001);
    check("s2_first_data", fifo_data, 1);
    wait_done("s2");
    done_cyc = cyc;
    check("s2_done_lat", done_cyc - last_wr_cyc, 1);
    check("s2_writes", wr_cnt, 24);
    check("s2_order_left", order_q.size(), 0);
    check_queues_empty("s2");

    // 3. leaf 2 blocked, then released
    fifo_full = 4'b0100;
    load_expected(1'b0);
    pulse_start();
    repeat (60) @(negedge clk);
    check("s3_partial_writes", wr_cnt, 18);
    check("s3_leaf2_pending", exp_q[2].size(), 6);
    check("s3_busy", busy, 1);
    check("s3_not_done", done, 0);
    fifo_full = '0;
    wait_done("s3");
    check("s3_writes", wr_cnt, 24);
    check_queues_empty("s3");

    // 4. leaf 0 blocked until the others finish: per-leaf pacing
    fifo_full = 4'b0001;
    load_expected(1'b0);
    pulse_start();
    repeat (60) @(negedge clk);
    check("s4_partial_writes", wr_cnt, 18);
    check("s4_rd_idle", mem_rd_en, 0);
    fifo_full = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("s4_rd_en_%0d", k), mem_rd_en, (k % 2 == 0) ? 1 : 0);
      check($sformatf("s4_wr0_%0d", k), fifo_write[0], (k % 2 == 1) ? 1 : 0);
    end
    wait_done("s4");
    check("s4_writes", wr_cnt, 24);
    check_queues_empty("s4");

    // 5. reset mid-pass after 7 writes
    load_expected(1'b1);
    pulse_start();
    n = 0;
    while (wr_cnt < 7 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("s5_reached_7", wr_cnt, 7);
    #2 rst_n = 1'b0;
    #1;
    check("s5_rst_write", fifo_write, 0);
    check("s5_rst_data", fifo_data, 0);
    check("s5_rst_rd_en", mem_rd_en, 0);
    check("s5_rst_addr", mem_addr, 0);
    check("s5_rst_busy", busy, 0);
    check("s5_rst_done", done, 0);
    for (int l = 0; l < int'(NL); l++) exp_q[l].delete();
    order_q.delete();
    chk_order = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr_cnt = 0;
    repeat (10) @(negedge clk);
    check("s5_quiet_writes", wr_cnt, 0);
    check("s5_quiet_busy", busy, 0);
    load_expected(1'b1);
    pulse_start();
    wait_done("s5");
    check("s5_writes", wr_cnt, 24);
    check("s5_order_left", order_q.size(), 0);
    check_queues_empty("s5");

    // 6. start ignored in RUN; start in DONE repeats the pass
    load_expected(1'b1);
    pulse_start();
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done("s6a");
    check("s6a_writes", wr_cnt, 24);
    check("s6a_order_left", order_q.size(), 0);
    check_queues_empty("s6a");
    load_expected(1'b1);
    pulse_start();
    check("s6_done_drops", done, 0);
    check("s6_busy_again", busy, 1);
    wait_done("s6b");
    check("s6b_writes", wr_cnt, 24);
    check("s6b_order_left", order_q.size(), 0);
    check_queues_empty("s6b");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
